// File: rtl/hazard_if.sv
// hazard_if: pipeline-state bundle between the five-stage core and hazard_ctrl.
//   master modport: the core drives the stage fields and reads the controls.
//   slave modport:  hazard_ctrl reads the stage fields and drives the controls.
//   Stage fields: ID sources/use flags, EX sources/dest/write/load/redirects,
//                 MEM/WB dests and write enables, dmem_req/dmem_ready.
//   Controls:     stalls, flushes, forward selects, state, sticky timeout flag.
interface hazard_if;
    logic [4:0] id_src1_addr, id_src2_addr;
    logic       id_uses_src1, id_uses_src2;
    logic [4:0] ex_src1_addr, ex_src2_addr, ex_dest_addr;
    logic       ex_reg_write, ex_is_load;
    logic       ex_jal_en, ex_jalr_en, ex_branch_taken;
    logic [4:0] mem_dest_addr, wb_dest_addr;
    logic       mem_reg_write, wb_reg_write;
    logic       dmem_req, dmem_ready;

    logic       pc_stall, ifid_stall, idex_stall, exmem_stall;
    logic       ifid_flush, idex_flush, memwb_flush;
    logic [1:0] forward_op1, forward_op2;
    logic [1:0] state;
    logic       mem_timeout_err;

    modport master (
        output id_src1_addr, id_src2_addr, id_uses_src1, id_uses_src2,
               ex_src1_addr, ex_src2_addr, ex_dest_addr, ex_reg_write, ex_is_load,
               ex_jal_en, ex_jalr_en, ex_branch_taken,
               mem_dest_addr, wb_dest_addr, mem_reg_write, wb_reg_write,
               dmem_req, dmem_ready,
        input  pc_stall, ifid_stall, idex_stall, exmem_stall,
               ifid_flush, idex_flush, memwb_flush,
               forward_op1, forward_op2, state, mem_timeout_err
    );

    modport slave (
        input  id_src1_addr, id_src2_addr, id_uses_src1, id_uses_src2,
               ex_src1_addr, ex_src2_addr, ex_dest_addr, ex_reg_write, ex_is_load,
               ex_jal_en, ex_jalr_en, ex_branch_taken,
               mem_dest_addr, wb_dest_addr, mem_reg_write, wb_reg_write,
               dmem_req, dmem_ready,
        output pc_stall, ifid_stall, idex_stall, exmem_stall,
               ifid_flush, idex_flush, memwb_flush,
               forward_op1, forward_op2, state, mem_timeout_err
    );
endinterface

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush/forward control for the five-stage RV32I pipeline.
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   hif (slave)     : stage fields in, stall/flush/forward/state/error out
//   Optional (macro HAZARD_PERF_CNT_EN): stall_cycles, flush_events,
//   mem_wait_cycles -- saturating CNT_W-bit performance counters.
// All controls are combinational from the current inputs and state; only
// the memory-wait FSM, its wait counter, the error flag and counters are
// registered.
module hazard_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic clk,
    input  logic rst,
    hazard_if.slave hif
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events,
    output logic [CNT_W-1:0] mem_wait_cycles
`endif
);

    localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT - 1);

    if (MEM_TIMEOUT < 2) begin : g_bad_timeout
        $error("hazard_ctrl: MEM_TIMEOUT must be >= 2");
    end
    if (CNT_W < 1) begin : g_bad_cnt_w
        $error("hazard_ctrl: CNT_W must be >= 1");
    end

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        ERR      = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              err_q, err_d;

    logic freeze, redirect, load_use;

    // MEM has priority over WB; x0 is hardwired zero so never forwarded.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic mem_we, input logic [4:0] mem_rd,
                                           input logic wb_we,  input logic [4:0] wb_rd);
        if (mem_we && mem_rd != 5'd0 && mem_rd == src)     return 2'b01;
        else if (wb_we && wb_rd != 5'd0 && wb_rd == src)   return 2'b10;
        else                                               return 2'b00;
    endfunction

    // Pipeline controls
    always_comb begin
        freeze   = (hif.dmem_req && !hif.dmem_ready) || (state_q == ERR);
        redirect = hif.ex_jal_en | hif.ex_jalr_en | hif.ex_branch_taken;
        load_use = hif.ex_is_load && hif.ex_reg_write && (hif.ex_dest_addr != 5'd0) &&
                   ((hif.id_uses_src1 && hif.id_src1_addr == hif.ex_dest_addr) ||
                    (hif.id_uses_src2 && hif.id_src2_addr == hif.ex_dest_addr));

        hif.pc_stall    = 1'b0;
        hif.ifid_stall  = 1'b0;
        hif.idex_stall  = 1'b0;
        hif.exmem_stall = 1'b0;
        hif.ifid_flush  = 1'b0;
        hif.idex_flush  = 1'b0;
        hif.memwb_flush = 1'b0;

        if (freeze) begin
            // Whole front end holds; WB gets a bubble since MEM has not finished.
            hif.pc_stall    = 1'b1;
            hif.ifid_stall  = 1'b1;
            hif.idex_stall  = 1'b1;
            hif.exmem_stall = 1'b1;
            hif.memwb_flush = 1'b1;
        end else if (redirect) begin
            // Wrong-path IF and ID instructions are squashed; a pending
            // load-use on the ID instruction is moot.
            hif.ifid_flush  = 1'b1;
            hif.idex_flush  = 1'b1;
        end else if (load_use) begin
            hif.pc_stall    = 1'b1;
            hif.ifid_stall  = 1'b1;
            hif.idex_flush  = 1'b1;
        end

        // Forward selects stay live under freeze because EX operands are held.
        hif.forward_op1 = fwd_sel(hif.ex_src1_addr, hif.mem_reg_write, hif.mem_dest_addr,
                                  hif.wb_reg_write, hif.wb_dest_addr);
        hif.forward_op2 = fwd_sel(hif.ex_src2_addr, hif.mem_reg_write, hif.mem_dest_addr,
                                  hif.wb_reg_write, hif.wb_dest_addr);

        hif.state           = state_q;
        hif.mem_timeout_err = err_q;
    end

    // Memory-wait FSM next state
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        case (state_q)
            RUN: begin
                wait_cnt_d = '0;
                if (hif.dmem_req && !hif.dmem_ready) state_d = MEM_WAIT;
            end
            MEM_WAIT: begin
                if (hif.dmem_ready) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WCNT_MAX) begin
                    state_d = ERR;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= RUN;
            wait_cnt_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
        end
    end

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
    logic [CNT_W-1:0] mwait_cnt_q, mwait_cnt_d;

    // Counters saturate at all-ones instead of wrapping.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        mwait_cnt_d = mwait_cnt_q;
        if (!freeze && !redirect && load_use && stall_cnt_q != '1)
            stall_cnt_d = stall_cnt_q + 1'b1;
        if (!freeze && redirect && flush_cnt_q != '1)
            flush_cnt_d = flush_cnt_q + 1'b1;
        if (freeze && mwait_cnt_q != '1)
            mwait_cnt_d = mwait_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mwait_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
            mwait_cnt_q <= mwait_cnt_d;
        end
    end

    assign stall_cycles    = stall_cnt_q;
    assign flush_events    = flush_cnt_q;
    assign mem_wait_cycles = mwait_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios followed by a randomized run, every
// cycle checked against a behavioural model of the hazard rules.
module tb_hazard_ctrl;
    localparam int TO    = 16;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    hazard_if hif();

`ifdef HAZARD_PERF_CNT_EN
    logic [CW-1:0] stall_cycles, flush_events, mem_wait_cycles;
`endif

    hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk),
        .rst(rst),
        .hif(hif)
`ifdef HAZARD_PERF_CNT_EN
        ,
        .stall_cycles(stall_cycles),
        .flush_events(flush_events),
        .mem_wait_cycles(mem_wait_cycles)
`endif
    );

    int checks   = 0;
    int failures = 0;

    // Model: memory phase (0 running, 1 waiting, 2 error), number of
    // not-ready cycles already spent waiting, sticky error, counters.
    int m_phase, m_waited, m_err;
    int m_stall, m_flush, m_mwait;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_waited = 0; m_err = 0;
        m_stall = 0; m_flush = 0; m_mwait = 0;
    endtask

    task automatic clr();
        hif.id_src1_addr = 0; hif.id_src2_addr = 0;
        hif.id_uses_src1 = 0; hif.id_uses_src2 = 0;
        hif.ex_src1_addr = 0; hif.ex_src2_addr = 0; hif.ex_dest_addr = 0;
        hif.ex_reg_write = 0; hif.ex_is_load = 0;
        hif.ex_jal_en = 0; hif.ex_jalr_en = 0; hif.ex_branch_taken = 0;
        hif.mem_dest_addr = 0; hif.wb_dest_addr = 0;
        hif.mem_reg_write = 0; hif.wb_reg_write = 0;
        hif.dmem_req = 0; hif.dmem_ready = 0;
    endtask

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (hif.mem_reg_write && hif.mem_dest_addr != 0 && hif.mem_dest_addr == src) return 2'b01;
        if (hif.wb_reg_write && hif.wb_dest_addr != 0 && hif.wb_dest_addr == src) return 2'b10;
        return 2'b00;
    endfunction

    // Called just after a rising edge with inputs already driven: checks
    // outputs mid-cycle, then advances the model across the next edge.
    task automatic step();
        logic fz, rd, lu;
        @(negedge clk);
        fz = (hif.dmem_req && !hif.dmem_ready) || (m_phase == 2);
        rd = hif.ex_jal_en || hif.ex_jalr_en || hif.ex_branch_taken;
        lu = hif.ex_is_load && hif.ex_reg_write && hif.ex_dest_addr != 0 &&
             ((hif.id_uses_src1 && hif.id_src1_addr == hif.ex_dest_addr) ||
              (hif.id_uses_src2 && hif.id_src2_addr == hif.ex_dest_addr));
        chk("pc_stall",    hif.pc_stall,    fz || (!rd && lu));
        chk("ifid_stall",  hif.ifid_stall,  fz || (!rd && lu));
        chk("idex_stall",  hif.idex_stall,  fz);
        chk("exmem_stall", hif.exmem_stall, fz);
        chk("ifid_flush",  hif.ifid_flush,  !fz && rd);
        chk("idex_flush",  hif.idex_flush,  !fz && (rd || lu));
        chk("memwb_flush", hif.memwb_flush, fz);
        chk("forward_op1", hif.forward_op1, exp_fwd(hif.ex_src1_addr));
        chk("forward_op2", hif.forward_op2, exp_fwd(hif.ex_src2_addr));
        chk("state",       hif.state,       m_phase);
        chk("timeout_err", hif.mem_timeout_err, m_err);
`ifdef HAZARD_PERF_CNT_EN
        chk("stall_cycles",    stall_cycles,    m_stall);
        chk("flush_events",    flush_events,    m_flush);
        chk("mem_wait_cycles", mem_wait_cycles, m_mwait);
`endif
        @(posedge clk);
        if (fz) m_mwait = (m_mwait < CMAX) ? m_mwait + 1 : CMAX;
        if (!fz && rd) m_flush = (m_flush < CMAX) ? m_flush + 1 : CMAX;
        if (!fz && !rd && lu) m_stall = (m_stall < CMAX) ? m_stall + 1 : CMAX;
        if (m_phase == 0) begin
            if (hif.dmem_req && !hif.dmem_ready) begin m_phase = 1; m_waited = 0; end
        end else if (m_phase == 1) begin
            if (hif.dmem_ready) m_phase = 0;
            else begin
                m_waited++;
                if (m_waited == TO) begin m_phase = 2; m_err = 1; end
            end
        end
        #1;
    endtask

    initial begin
        clr();
        model_reset();

        // Reset state with all inputs low: every output is 0.
        @(negedge clk);
        chk("rst_pc_stall", hif.pc_stall, 0);
        chk("rst_flushes", {hif.ifid_flush, hif.idex_flush, hif.memwb_flush}, 0);
        chk("rst_fwd", {hif.forward_op1, hif.forward_op2}, 0);
        chk("rst_state", hif.state, 0);
        chk("rst_err", hif.mem_timeout_err, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        step();

        // Load-use then forward from MEM next cycle.
        hif.ex_is_load = 1; hif.ex_reg_write = 1; hif.ex_dest_addr = 5;
        hif.id_src1_addr = 5; hif.id_uses_src1 = 1;
        #1;
        chk("lu_pc_stall", hif.pc_stall, 1);
        chk("lu_idex_flush", hif.idex_flush, 1);
        step();
        clr();
        hif.mem_dest_addr = 5; hif.mem_reg_write = 1; hif.ex_src1_addr = 5;
        #1;
        chk("lu_fwd01", hif.forward_op1, 2'b01);
        chk("lu_no_stall", hif.pc_stall, 0);
        step();

        // Forward priority MEM > WB, then x0.
        clr();
        hif.mem_dest_addr = 7; hif.wb_dest_addr = 7;
        hif.mem_reg_write = 1; hif.wb_reg_write = 1; hif.ex_src2_addr = 7;
        #1; chk("fwd_mem", hif.forward_op2, 2'b01);
        step();
        hif.mem_reg_write = 0;
        #1; chk("fwd_wb", hif.forward_op2, 2'b10);
        step();
        hif.mem_reg_write = 1; hif.mem_dest_addr = 0; hif.wb_dest_addr = 0; hif.ex_src2_addr = 0;
        #1; chk("fwd_x0", hif.forward_op2, 2'b00);
        step();

        // Redirect with load-use in the same cycle.
        clr();
        hif.ex_is_load = 1; hif.ex_reg_write = 1; hif.ex_dest_addr = 9;
        hif.id_src2_addr = 9; hif.id_uses_src2 = 1; hif.ex_jalr_en = 1;
        #1;
        chk("rd_lu_pc_stall", hif.pc_stall, 0);
        chk("rd_lu_flushes", {hif.ifid_flush, hif.idex_flush}, 2'b11);
        step();

        // Memory wait: 3 not-ready cycles then ready.
        clr();
        hif.dmem_req = 1;
        for (int i = 0; i < 3; i++) step();
        hif.dmem_ready = 1;
        #1; chk("mw_ready_no_freeze", hif.exmem_stall, 0);
        step();
        clr();
        chk("mw_back_run", hif.state, 0);
        step();
`ifdef HAZARD_PERF_CNT_EN
        chk("perf_stall", stall_cycles, 1);
        chk("perf_flush", flush_events, 1);
        chk("perf_mwait", mem_wait_cycles, 3);
`endif

        // Timeout: one running cycle plus TO waiting cycles reach the error state.
        hif.dmem_req = 1;
        for (int i = 0; i < TO + 1; i++) step();
        chk("to_state", hif.state, 2'b10);
        chk("to_err", hif.mem_timeout_err, 1);
        hif.dmem_req = 0;
        #1; chk("to_freeze_held", hif.memwb_flush, 1);
        step();
        step();

        // Asynchronous reset out of the error state.
        rst = 1'b1;
        #1;
        chk("arst_state", hif.state, 0);
        chk("arst_err", hif.mem_timeout_err, 0);
        model_reset();
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            hif.id_src1_addr   = 5'($urandom_range(0, 3));
            hif.id_src2_addr   = 5'($urandom_range(0, 3));
            hif.id_uses_src1   = 1'($urandom);
            hif.id_uses_src2   = 1'($urandom);
            hif.ex_src1_addr   = 5'($urandom_range(0, 3));
            hif.ex_src2_addr   = 5'($urandom_range(0, 3));
            hif.ex_dest_addr   = 5'($urandom_range(0, 3));
            hif.ex_reg_write   = 1'($urandom);
            hif.ex_is_load     = 1'($urandom);
            hif.ex_jal_en      = ($urandom_range(0, 7) == 0);
            hif.ex_jalr_en     = ($urandom_range(0, 7) == 0);
            hif.ex_branch_taken = ($urandom_range(0, 5) == 0);
            hif.mem_dest_addr  = 5'($urandom_range(0, 3));
            hif.wb_dest_addr   = 5'($urandom_range(0, 3));
            hif.mem_reg_write  = 1'($urandom);
            hif.wb_reg_write   = 1'($urandom);
            hif.dmem_req       = 1'($urandom);
            hif.dmem_ready     = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. It drives the stall, flush and forwarding controls for the IF/ID, ID/EX (RegDA), EX/MEM and MEM/WB registers. It detects load-use hazards, branch and jump redirects, and data-memory wait states. A small state machine tracks multi-cycle memory stalls and latches a sticky error when a memory timeout occurs.

## Interface
Parameters:
- MEM_TIMEOUT, 16, number of consecutive MEM_WAIT cycles that trips the timeout error (≥2)
- CNT_W, 32, width of the performance counters

Ports:
- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- id_src1_addr / id_src2_addr  in  5  source registers of the instruction in ID
- id_uses_src1 / id_uses_src2  in  1  ID instruction actually reads that source
- ex_src1_addr / ex_src2_addr  in  5  src_reg1/2_addr_out of ID/EX
- ex_dest_addr  in  5  destination of the EX instruction
- ex_reg_write, ex_is_load  in  1  EX writes rd / EX is a load
- ex_jal_en, ex_jalr_en, ex_branch_taken  in  1  control-flow redirect resolved in EX
- mem_dest_addr, wb_dest_addr  in  5  destinations in MEM and WB
- mem_reg_write, wb_reg_write  in  1  write enables in MEM and WB
- dmem_req  in  1  MEM stage has a data access outstanding
- dmem_ready  in  1  data memory completes the access this cycle
- pc_stall, ifid_stall, idex_stall, exmem_stall  out  1  hold register contents
- ifid_flush, idex_flush, memwb_flush  out  1  load a bubble (NOP, all enables 0)
- forward_op1, forward_op2  out  2  EX operand select: 00 register file, 01 alu_mem_data, 10 wb_data
- state  out  2  00 RUN, 01 MEM_WAIT, 10 ERR
- mem_timeout_err  out  1  sticky timeout flag

## Operation
- Three states:
  - RUN: if dmem_req && !dmem_ready, go to MEM_WAIT.
  - MEM_WAIT: if dmem_ready, go to RUN. If wait_cnt == MEM_TIMEOUT-1 and not ready, go to ERR.
  - ERR: terminal until rst.
- wait_cnt counts cycles spent in MEM_WAIT. It clears on entering RUN.
- freeze = (dmem_req && !dmem_ready) || state==ERR. When freeze is set:
  - pc_stall, ifid_stall, idex_stall and exmem_stall are 1.
  - memwb_flush is 1.
  - All other flushes are 0.
- redirect = ex_jal_en | ex_jalr_en | ex_branch_taken. When redirect is set and freeze is not:
  - ifid_flush and idex_flush are 1.
  - No stall outputs are asserted.
- load_use = ex_is_load && ex_reg_write && ex_dest_addr!=0 && ((id_uses_src1 && id_src1_addr==ex_dest_addr) || (id_uses_src2 && id_src2_addr==ex_dest_addr)). When load_use is set and neither freeze nor redirect is:
  - pc_stall and ifid_stall are 1.
  - idex_flush is 1.
- Priority is freeze > redirect > load_use. A redirect suppresses load_use because the ID instruction is discarded anyway.
- Forwarding for op1 (op2 is identical):
  - 01 if mem_reg_write && mem_dest_addr!=0 && mem_dest_addr==ex_src1_addr.
  - Otherwise 10 if the same condition holds for WB.
  - Otherwise 00.
  - MEM has priority over WB.
  - Register x0 is never forwarded.
- Forwarding outputs stay valid during freeze, because the EX operands are held.

## Timing
- Stall, flush and forward outputs are combinational from the current inputs and state. No added latency: hazards are resolved in the same cycle they appear.
- A load-use stall lasts exactly 1 cycle. In the next cycle the load is in MEM and the dependency is covered by forward 01.
- A redirect costs 2 bubbles (IF/ID and ID/EX) in the single cycle it is asserted.
- Memory wait: the freeze lasts as long as dmem_ready is low. The cycle in which dmem_ready rises has no freeze and the pipeline advances.
- The state register, wait_cnt, mem_timeout_err and the counters update on the rising clk edge.
- Reset values:
  - state=RUN, wait_cnt=0, mem_timeout_err=0, all counters 0.
  - With all inputs at 0, every output is 0.
- Reset asserted mid-MEM_WAIT or in ERR returns the block to RUN immediately (asynchronous).
- mem_timeout_err goes to 1 on the edge that enters ERR and stays at 1 until rst.

## Configuration
- HAZARD_PERF_CNT_EN defined: adds three CNT_W-bit output ports, each a saturating counter (holds at all-ones):
  - stall_cycles: cycles with load_use taking effect.
  - flush_events: cycles with redirect taking effect.
  - mem_wait_cycles: cycles with freeze.
- HAZARD_PERF_CNT_EN undefined: these ports and their registers do not exist. All other behaviour is identical.

## Test plan
- Load-use: ex_is_load=1, ex_reg_write=1, ex_dest_addr=5, id_src1_addr=5, id_uses_src1=1 -> pc_stall=ifid_stall=idex_flush=1 for 1 cycle. On the next cycle, with mem_dest_addr=5 and ex_src1_addr=5 -> forward_op1=01.
- Forward priority: mem_dest=wb_dest=7, both write enables 1, ex_src2_addr=7 -> forward_op2=01. With mem_reg_write=0 -> 10. With all dests=0 and ex_src2_addr=0 -> 00.
- Redirect plus load-use in the same cycle: ex_jalr_en=1 with load_use conditions true -> ifid_flush=idex_flush=1, pc_stall=0.
- Memory wait: dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> all stalls and memwb_flush=1 for 3 cycles, state=01. The pipeline advances on the ready cycle and state returns to 00.
- Timeout: dmem_ready held at 0 for MEM_TIMEOUT=16 cycles -> state=10 and mem_timeout_err=1, with the freeze held. Asserting rst -> state=00, error flag cleared.
- With HAZARD_PERF_CNT_EN defined, after the first four scenarios -> stall_cycles=1, flush_events=1, mem_wait_cycles=3.
